phase_sweep_ctrl: RTL

Sequencing controller for the 32-bit phase ring counter in the sine-wave generator. It accepts a sweep descriptor through a valid/ready handshake and issues a synchronous clear to the counter. It then drives the counter's per-clock phase increment from a start value to a stop value in fixed steps, holding each value for a programmable dwell. It sits between the register/host interface and the phase counter, producing linear frequency chirps in one-shot or repeat mode.

---
 rtl/phase_sweep_pkg.sv | 10 +
 rtl/phase_sweep_ctrl_if.sv | 31 +++
 rtl/phase_sweep_dwell_timer.sv | 25 ++
 rtl/phase_sweep_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/phase_sweep_pkg.sv
// Shared types and default sizes for the phase sweep controller.
package phase_sweep_pkg;
  localparam int WIDTH_DEF   = 32;
  localparam int DWELL_W_DEF = 16;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, STEP} state_t;

  // Matches the phase counter's DIRECTION input encoding.
  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;
endpackage

// File: rtl/phase_sweep_ctrl_if.sv
// Host-side descriptor handshake plus the controller's outputs toward the phase counter.
interface phase_sweep_ctrl_if
  import phase_sweep_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DWELL_W = DWELL_W_DEF
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [WIDTH-1:0]   cfg_start;
  logic [WIDTH-1:0]   cfg_stop;
  logic [WIDTH-1:0]   cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               cfg_repeat;
  logic               cfg_pingpong;
  logic               abort;
  logic [WIDTH-1:0]   inc_out;
  logic               ctr_sclr;
  logic               busy;
  logic               done;

  modport master (
    output cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_repeat, cfg_pingpong, abort,
    input  cfg_ready, inc_out, ctr_sclr, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_repeat, cfg_pingpong, abort,
    output cfg_ready, inc_out, ctr_sclr, busy, done
  );
endinterface

// File: rtl/phase_sweep_dwell_timer.sv
// Loadable dwell down-counter; a load of N gives a terminal count N cycles later (0 acts as 1).
module phase_sweep_dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               load,
  input  logic               en,
  input  logic [DWELL_W-1:0] value,
  output logic               tc
);
  logic [DWELL_W-1:0] cnt_q;

  // The loading cycle itself counts as the first held cycle, hence value-1.
  always_ff @(posedge CLK) begin
    if (!RST_N)
      cnt_q <= '0;
    else if (load)
      cnt_q <= (value == '0) ? '0 : value - DWELL_W'(1);
    else if (en && cnt_q != '0)
      cnt_q <= cnt_q - DWELL_W'(1);
  end

  assign tc = (cnt_q == '0);
endmodule

// File: rtl/phase_sweep_ctrl.sv
// Sweeps the phase increment start->stop in clamped steps, each held max(dwell,1) cycles; all outputs registered,
// descriptor taken only in IDLE (cfg_ready), abort wins next cycle. PHASE_SWEEP_PINGPONG_EN adds endpoint reversal.
module phase_sweep_ctrl
  import phase_sweep_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input logic               CLK,
  input logic               RST_N,
  phase_sweep_ctrl_if.slave bus
);
  state_t             state_q;
  logic [WIDTH-1:0]   inc_q, tgt_q, start_q, stop_q, step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               rpt_q, sclr_q, busy_q, done_q, rdy_q;
  logic               accept, tmr_tc, tmr_load, at_end;
  logic [DWELL_W-1:0] tmr_val;
  logic [WIDTH-1:0]   nxt_inc;

  // One clamped step toward tgt; WIDTH+1 bits catch both wrap directions.
  function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur, tgt, stp);
    logic [WIDTH:0] nxt;
    dir_t           dir;
    dir = (tgt >= cur) ? DIR_UP : DIR_DOWN;
    if (dir == DIR_UP) begin
      nxt = {1'b0, cur} + {1'b0, stp};
      if (nxt > {1'b0, tgt}) nxt = {1'b0, tgt};
    end else begin
      nxt = {1'b0, cur} - {1'b0, stp};
      if (nxt[WIDTH] || nxt < {1'b0, tgt}) nxt = {1'b0, tgt};
    end
    return nxt[WIDTH-1:0];
  endfunction

  assign accept   = (state_q == IDLE) && bus.cfg_valid && !bus.abort;
  assign tmr_load = accept || ((state_q != IDLE) && tmr_tc);
  assign tmr_val  = accept ? bus.cfg_dwell : dwell_q;
  assign at_end   = (inc_q == tgt_q) || (step_q == '0);
  assign nxt_inc  = step_toward(inc_q, tgt_q, step_q);

`ifdef PHASE_SWEEP_PINGPONG_EN
  logic             pp_q, back_q, rev_ok;
  logic [WIDTH-1:0] rev_tgt, rev_inc;
  // Leaving the stop end always reverses; leaving the start end only when repeating.
  assign rev_ok  = pp_q && (step_q != '0) && (start_q != stop_q) && (!back_q || rpt_q);
  assign rev_tgt = back_q ? stop_q : start_q;
  assign rev_inc = step_toward(inc_q, rev_tgt, step_q);
`else
  logic unused_pingpong;
  assign unused_pingpong = bus.cfg_pingpong;
`endif

  phase_sweep_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
    .CLK   (CLK),
    .RST_N (RST_N),
    .load  (tmr_load),
    .en    (state_q != IDLE),
    .value (tmr_val),
    .tc    (tmr_tc)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      inc_q   <= '0;
      tgt_q   <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      rpt_q   <= 1'b0;
      sclr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
`ifdef PHASE_SWEEP_PINGPONG_EN
      pp_q    <= 1'b0;
      back_q  <= 1'b0;
`endif
    end else begin
      sclr_q <= 1'b0;
      done_q <= 1'b0;
      if (bus.abort) begin
        state_q <= IDLE;
        inc_q   <= '0;
        busy_q  <= 1'b0;
        rdy_q   <= 1'b1;
      end else begin
        case (state_q)
          IDLE: if (bus.cfg_valid) begin
            start_q <= bus.cfg_start;
            stop_q  <= bus.cfg_stop;
            tgt_q   <= bus.cfg_stop;
            step_q  <= bus.cfg_step;
            dwell_q <= bus.cfg_dwell;
            rpt_q   <= bus.cfg_repeat;
            inc_q   <= bus.cfg_start;
            sclr_q  <= 1'b1;
            busy_q  <= 1'b1;
            rdy_q   <= 1'b0;
            state_q <= CLEAR;
`ifdef PHASE_SWEEP_PINGPONG_EN
            pp_q    <= bus.cfg_pingpong;
            back_q  <= 1'b0;
`endif
          end
          CLEAR, RUN, STEP: begin
            if (!tmr_tc) begin
              state_q <= RUN;
            end else if (!at_end) begin
              inc_q   <= nxt_inc;
              state_q <= STEP;
`ifdef PHASE_SWEEP_PINGPONG_EN
            end else if (rev_ok) begin
              back_q  <= !back_q;
              tgt_q   <= rev_tgt;
              inc_q   <= rev_inc;
              state_q <= STEP;
`endif
            end else if (rpt_q) begin
              // Wrap without a counter clear so the output phase stays continuous.
              inc_q   <= start_q;
              tgt_q   <= stop_q;
              state_q <= STEP;
`ifdef PHASE_SWEEP_PINGPONG_EN
              back_q  <= 1'b0;
`endif
            end else begin
              state_q <= IDLE;
              inc_q   <= '0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              rdy_q   <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            inc_q   <= '0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.cfg_ready = rdy_q;
  assign bus.inc_out   = inc_q;
  assign bus.ctr_sclr  = sclr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule
